// File: rtl/ray_sched_pkg.sv
// Shared types and constants for the ray-direction dispatch scheduler and pipeline.
package ray_sched_pkg;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  localparam int unsigned WIDTH_HALF  = 256;
  localparam int unsigned HEIGHT_HALF = 192;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } coord_t;

endpackage

// File: rtl/ray_dispatch_scheduler_coord_fifo.sv
// First-word fall-through coordinate FIFO; the head is visible combinationally.
module coord_fifo
  import ray_sched_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter type         data_t = coord_t
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push_in,
  input  data_t                  data_in,
  input  logic                   pop_in,
  output data_t                  data_out,
  output logic                   full_out,
  output logic                   empty_out,
  output logic [$clog2(DEPTH):0] count_out
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  data_t         mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          do_push;
  logic          do_pop;

  assign empty_out = (wptr_q == rptr_q);
  assign full_out  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_out = wptr_q - rptr_q;
  assign data_out  = mem_q[rptr_q[AW-1:0]];

  // A pop on empty is dropped; a push on full is accepted only alongside a pop.
  assign do_pop  = pop_in && !empty_out;
  assign do_push = push_in && (!full_out || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/ray_dispatch_scheduler.sv
// Raster-order ray issue scheduler: credit-gated pixel issue, frame-latched head
// position, and FIFO re-pairing of returning directions with their coordinates.
module ray_dispatch_scheduler
  import ray_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 512,
  parameter int unsigned HEIGHT  = 384,
  parameter int unsigned CREDITS = 128
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           frame_start_in,
  input  logic [31:0]    head_x_in,
  input  logic [31:0]    head_y_in,
  input  logic [31:0]    head_z_in,
  output logic [X_W-1:0] pix_x_out,
  output logic [Y_W-1:0] pix_y_out,
  output logic           pix_valid_out,
  output logic [31:0]    head_x_out,
  output logic [31:0]    head_y_out,
  output logic [31:0]    head_z_out,
  input  logic           dir_valid_in,
  input  logic           res_pop_in,
  output logic [X_W-1:0] ray_x_out,
  output logic [Y_W-1:0] ray_y_out,
  output logic           ray_valid_out,
  output logic           busy_out,
  output logic           frame_done_out,
  output logic           error_out
);
  localparam int unsigned    CW           = $clog2(CREDITS) + 1;
  localparam logic [X_W-1:0] X_LAST       = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST       = Y_W'(HEIGHT - 1);
  localparam logic [CW-1:0]  CREDITS_FULL = CW'(CREDITS);

  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           pix_valid_q, pix_valid_d;
  logic [X_W-1:0] pix_x_q, pix_x_d;
  logic [Y_W-1:0] pix_y_q, pix_y_d;
  logic [31:0]    head_x_q, head_x_d;
  logic [31:0]    head_y_q, head_y_d;
  logic [31:0]    head_z_q, head_z_d;
  logic           frame_done_q, frame_done_d;
  logic [CW-1:0]  credits_q, credits_d;
  logic           error_q, error_d;
  logic           issue_c;

  coord_t         fifo_wdata;
  coord_t         fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  assign fifo_wdata = '{x: x_q, y: y_q};

  coord_fifo #(
    .DEPTH  (CREDITS),
    .data_t (coord_t)
  ) u_coord_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (issue_c),
    .data_in   (fifo_wdata),
    .pop_in    (dir_valid_in),
    .data_out  (fifo_rdata),
    .full_out  (fifo_full),
    .empty_out (fifo_empty),
    .count_out (fifo_count)
  );

  // Frame sequencing and raster issue.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    head_x_d     = head_x_q;
    head_y_d     = head_y_q;
    head_z_d     = head_z_q;
    frame_done_d = 1'b0;
    issue_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          head_x_d = head_x_in;
          head_y_d = head_y_in;
          head_z_d = head_z_in;
          x_d      = '0;
          y_d      = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if ((credits_q != '0) && !fifo_full) begin
          issue_c     = 1'b1;
          pix_valid_d = 1'b1;
          pix_x_d     = x_q;
          pix_y_d     = y_q;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = DRAIN;
            end else begin
              y_d = y_q + Y_W'(1);
            end
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      DRAIN: begin
        // Done pulse is raised while still in DRAIN so a coincident start is ignored.
        if (frame_done_q) begin
          state_d = IDLE;
        end else if (fifo_empty || ((fifo_count == CW'(1)) && dir_valid_in)) begin
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit accounting and sticky protocol errors.
  always_comb begin
    credits_d = credits_q;
    error_d   = error_q;
    if (issue_c && !res_pop_in) begin
      credits_d = credits_q - CW'(1);
    end else if (!issue_c && res_pop_in) begin
      if (credits_q == CREDITS_FULL) error_d = 1'b1;
      else                           credits_d = credits_q + CW'(1);
    end
    if (dir_valid_in && fifo_empty) error_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      head_x_q     <= '0;
      head_y_q     <= '0;
      head_z_q     <= '0;
      frame_done_q <= 1'b0;
      credits_q    <= CREDITS_FULL;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      head_x_q     <= head_x_d;
      head_y_q     <= head_y_d;
      head_z_q     <= head_z_d;
      frame_done_q <= frame_done_d;
      credits_q    <= credits_d;
      error_q      <= error_d;
    end
  end

  assign pix_x_out      = pix_x_q;
  assign pix_y_out      = pix_y_q;
  assign pix_valid_out  = pix_valid_q;
  assign head_x_out     = head_x_q;
  assign head_y_out     = head_y_q;
  assign head_z_out     = head_z_q;
  assign ray_x_out      = fifo_rdata.x;
  assign ray_y_out      = fifo_rdata.y;
  assign ray_valid_out  = dir_valid_in;
  assign busy_out       = (state_q != IDLE);
  assign frame_done_out = frame_done_q;
  assign error_out      = error_q;

endmodule
